// File: rtl/bm_crc_unit.sv
`default_nettype none
// ============================================================================
// Module      : bm_crc_unit
// Description : Bit-serial CRC32 / CRC32C unit. Each accepted request
//               processes the operand for 8, 16, 32 or 64 reflected-CRC
//               iterations, one iteration per clock. The result is held
//               until the consumer takes it or a flush discards it.
// Ports       : clk_i             - clock, all state on the rising edge
//               rst_ni            - asynchronous active-low reset
//               flush_i           - abort any in-flight operation
//               valid_i / ready_o - request handshake (ready only in IDLE)
//               operation_i       - function code; [1:0] size, [2] CRC32C
//               operand_a_i       - rs1 value
//               trans_id_i        - request transaction ID
//               result_o          - CRC result
//               result_valid_o    - result_o / result_trans_id_o valid
//               result_trans_id_o - ID of the returned result
//               result_ready_i    - consumer takes the result this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module bm_crc_unit #(
    parameter int XLEN          = 64,
    parameter int TRANS_ID_BITS = 3,
    localparam int BM_FUNC_NBITS = 9
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [BM_FUNC_NBITS-1:0] operation_i,
    input  logic [XLEN-1:0]          operand_a_i,
    input  logic [TRANS_ID_BITS-1:0] trans_id_i,
    output logic [XLEN-1:0]          result_o,
    output logic                     result_valid_o,
    output logic [TRANS_ID_BITS-1:0] result_trans_id_o,
    input  logic                     result_ready_i
);

    localparam logic [31:0] CRC32_POLY  = 32'hEDB88320;
    localparam logic [31:0] CRC32C_POLY = 32'h82F63B78;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [6:0]               cnt_q, cnt_d;
    logic [XLEN-1:0]          x_q, x_d;
    logic [TRANS_ID_BITS-1:0] id_q, id_d;
    logic                     sel_q, sel_d;

    logic [XLEN-1:0]          poly_ext;
    logic [6:0]               iter_count;

    // Only the size and polynomial-select bits of the function code matter.
    logic unused_op_bits;
    assign unused_op_bits = ^operation_i[BM_FUNC_NBITS-1:3];

    assign poly_ext = XLEN'(sel_q ? CRC32C_POLY : CRC32_POLY);

    always_comb begin
        iter_count = 7'd8;
        case (operation_i[1:0])
            2'b00:   iter_count = 7'd8;
            2'b01:   iter_count = 7'd16;
            2'b10:   iter_count = 7'd32;
            default: iter_count = 7'd64;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= 7'd0;
            x_q     <= '0;
            id_q    <= '0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            id_q    <= id_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        id_d    = id_q;
        sel_d   = sel_q;
        case (state_q)
            IDLE: begin
                if (valid_i && !flush_i) begin
                    state_d = BUSY;
                    x_d     = operand_a_i;
                    id_d    = trans_id_i;
                    sel_d   = operation_i[2];
                    cnt_d   = iter_count;
                end
            end
            BUSY: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    // Reflected CRC step: logical shift right, fold the
                    // polynomial in when the bit shifted out was a one.
                    x_d   = (x_q >> 1) ^ (x_q[0] ? poly_ext : '0);
                    cnt_d = cnt_q - 7'd1;
                    if (cnt_q == 7'd1) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // Flush and result consumption both return to IDLE.
                if (flush_i || result_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ready_o           = (state_q == IDLE);
    assign result_valid_o    = (state_q == DONE);
    assign result_o          = (state_q == DONE) ? x_q  : '0;
    assign result_trans_id_o = (state_q == DONE) ? id_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_bm_crc_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_bm_crc_unit
// Description : Self-checking bench for bm_crc_unit: directed scenarios
//               plus randomized requests against a reference CRC model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bm_crc_unit;

    localparam int XLEN = 64;
    localparam int TIDB = 3;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            flush_i = 1'b0;
    logic            valid_i = 1'b0;
    logic            ready_o;
    logic [8:0]      operation_i = '0;
    logic [XLEN-1:0] operand_a_i = '0;
    logic [TIDB-1:0] trans_id_i = '0;
    logic [XLEN-1:0] result_o;
    logic            result_valid_o;
    logic [TIDB-1:0] result_trans_id_o;
    logic            result_ready_i = 1'b0;

    int checks = 0;
    int errors = 0;

    bm_crc_unit #(.XLEN(XLEN), .TRANS_ID_BITS(TIDB)) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .flush_i           (flush_i),
        .valid_i           (valid_i),
        .ready_o           (ready_o),
        .operation_i       (operation_i),
        .operand_a_i       (operand_a_i),
        .trans_id_i        (trans_id_i),
        .result_o          (result_o),
        .result_valid_o    (result_valid_o),
        .result_trans_id_o (result_trans_id_o),
        .result_ready_i    (result_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int n_iter(input logic [8:0] op);
        return 8 << op[1:0];
    endfunction

    // Reference: reflected CRC, one bit per step, straight from the rule.
    function automatic logic [63:0] ref_crc(input logic [8:0] op, input logic [63:0] a);
        logic [63:0] x;
        logic [63:0] poly;
        x    = a;
        poly = op[2] ? 64'h0000_0000_82F6_3B78 : 64'h0000_0000_EDB8_8320;
        for (int i = 0; i < n_iter(op); i++) begin
            if (x[0]) x = (x >> 1) ^ poly;
            else      x = x >> 1;
        end
        return x;
    endfunction

    // All tasks are entered just after a falling edge.
    task automatic start_req(input logic [8:0] op, input logic [63:0] a, input logic [2:0] id);
        chk("ready_before_req", {63'd0, ready_o}, 64'd1);
        valid_i     = 1'b1;
        operation_i = op;
        operand_a_i = a;
        trans_id_i  = id;
        @(negedge clk_i);
        valid_i     = 1'b0;
        operand_a_i = 64'hDEAD_BEEF_0BAD_F00D;
        trans_id_i  = ~id;
        chk("ready_after_accept", {63'd0, ready_o}, 64'd0);
    endtask

    task automatic wait_result(input string tag, input int n, input logic [63:0] exp,
                               input logic [2:0] id);
        int cyc;
        bit busy_ok;
        cyc     = 0;
        busy_ok = 1'b1;
        while (result_valid_o !== 1'b1 && cyc < 100) begin
            if (ready_o !== 1'b0 || result_valid_o !== 1'b0) busy_ok = 1'b0;
            @(negedge clk_i);
            cyc++;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'(n));
        chk({tag, "_busy_outputs"}, {63'd0, busy_ok}, 64'd1);
        chk({tag, "_result"}, result_o, exp);
        chk({tag, "_id"}, {61'd0, result_trans_id_o}, {61'd0, id});
    endtask

    task automatic release_result();
        result_ready_i = 1'b1;
        @(negedge clk_i);
        result_ready_i = 1'b0;
        chk("idle_after_release_ready", {63'd0, ready_o}, 64'd1);
        chk("idle_after_release_valid", {63'd0, result_valid_o}, 64'd0);
    endtask

    initial begin
        logic [8:0]  op;
        logic [63:0] a;
        logic [2:0]  id;
        logic [63:0] held;
        int          hold;

        // Reset state, asserted from time zero before any clock edge.
        #1;
        chk("rst_ready", {63'd0, ready_o}, 64'd1);
        chk("rst_valid", {63'd0, result_valid_o}, 64'd0);
        chk("rst_result", result_o, 64'd0);
        chk("rst_id", {61'd0, result_trans_id_o}, 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // CRCB of 0xFF.
        start_req(9'h000, 64'h0000_0000_0000_00FF, 3'd2);
        wait_result("crcb", 8, 64'h0000_0000_2D02_EF8D, 3'd2);
        release_result();

        // CRCCB of 1.
        start_req(9'h004, 64'h1, 3'd5);
        wait_result("crccb", 8, 64'h0000_0000_F26B_8303, 3'd5);
        release_result();

        // CRCD of zero: 64 iterations.
        start_req(9'h003, 64'h0, 3'd1);
        wait_result("crcd_zero", 64, 64'h0, 3'd1);
        release_result();

        // Hold in DONE with a competing request pending.
        a = {$urandom, $urandom};
        start_req(9'h001, a, 3'd6);
        wait_result("crch_hold", 16, ref_crc(9'h001, a), 3'd6);
        held        = result_o;
        valid_i     = 1'b1;
        operation_i = 9'h002;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("hold_result", result_o, held);
            chk("hold_valid", {63'd0, result_valid_o}, 64'd1);
            chk("hold_ready", {63'd0, ready_o}, 64'd0);
        end
        valid_i = 1'b0;
        release_result();

        // Flush in BUSY cycle 3 of CRCW, then a new request right after.
        start_req(9'h002, {$urandom, $urandom}, 3'd3);
        @(negedge clk_i);
        @(negedge clk_i);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        chk("flush_busy_ready", {63'd0, ready_o}, 64'd1);
        chk("flush_busy_valid", {63'd0, result_valid_o}, 64'd0);
        a = {$urandom, $urandom};
        start_req(9'h006, a, 3'd4);
        wait_result("after_flush", 32, ref_crc(9'h006, a), 3'd4);
        release_result();

        // Flush in DONE discards the result.
        start_req(9'h000, 64'h1234, 3'd7);
        wait_result("pre_flush_done", 8, ref_crc(9'h000, 64'h1234), 3'd7);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        chk("flush_done_valid", {63'd0, result_valid_o}, 64'd0);
        chk("flush_done_ready", {63'd0, ready_o}, 64'd1);

        // Flush together with valid in IDLE: not accepted.
        valid_i     = 1'b1;
        flush_i     = 1'b1;
        operation_i = 9'h000;
        @(negedge clk_i);
        valid_i = 1'b0;
        flush_i = 1'b0;
        chk("flush_valid_idle_ready", {63'd0, ready_o}, 64'd1);
        @(negedge clk_i);
        chk("flush_valid_idle_novalid", {63'd0, result_valid_o}, 64'd0);

        // Reset pulse in BUSY.
        start_req(9'h007, {$urandom, $urandom}, 3'd5);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        chk("midrst_ready", {63'd0, ready_o}, 64'd1);
        chk("midrst_valid", {63'd0, result_valid_o}, 64'd0);
        chk("midrst_result", result_o, 64'd0);
        chk("midrst_id", {61'd0, result_trans_id_o}, 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("postrst_ready", {63'd0, ready_o}, 64'd1);
        chk("postrst_valid", {63'd0, result_valid_o}, 64'd0);

        // Randomized requests against the reference model.
        for (int k = 0; k < 16; k++) begin
            op   = 9'($urandom);
            a    = {$urandom, $urandom};
            id   = 3'($urandom);
            hold = $urandom_range(0, 3);
            start_req(op, a, id);
            wait_result("rand", n_iter(op), ref_crc(op, a), id);
            for (int h = 0; h < hold; h++) @(negedge clk_i);
            chk("rand_hold", result_o, ref_crc(op, a));
            release_result();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
